// File: rtl/rr_packet_arbiter.sv
// Round-robin output arbiter: packet-locked grants with RR_PACKET_ARB_LOCK_EN defined, flit-granular otherwise.
// Grant is registered one cycle after arbitration. out_ready=0 stalls the owner and never releases the grant.

module rr_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end
endmodule

module rr_packet_arbiter #(
  parameter int N_REQ     = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     tail,
  input  logic                 out_ready,
  output logic [N_REQ-1:0]     grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_valid,
  output logic                 xfer
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state_q, state_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic                 valid_q, valid_d;

  logic [N_REQ-1:0]     arb_req;
  logic [N_REQ-1:0]     rot_req;
  logic                 enc_found;
  logic [IDX_WIDTH-1:0] enc_idx;
  logic [IDX_WIDTH-1:0] win_idx;
  logic                 owner_req;
  logic                 release_own;

  // grant_q is one-hot or zero, so this equals req[grant_idx] while valid
  assign owner_req = |(grant_q & req);
  assign xfer      = valid_q & owner_req & out_ready;

`ifdef RR_PACKET_ARB_LOCK_EN
  assign release_own = (xfer & |(grant_q & tail)) | ~owner_req;
`else
  logic unused_tail;
  assign unused_tail = ^tail;
  assign release_own = xfer | ~owner_req;
`endif

  // Masking the current owner gives the zero-bubble handover to someone else
  assign arb_req = (state_q == BUSY) ? (req & ~grant_q) : req;

  always_comb begin
    rot_req = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rot_req[k] = arb_req[(int'(ptr_q) + 1 + k) % N_REQ];
    end
  end

  rr_prio_enc #(
    .N (N_REQ),
    .W (IDX_WIDTH)
  ) u_prio_enc (
    .vec   (rot_req),
    .found (enc_found),
    .idx   (enc_idx)
  );

  assign win_idx = IDX_WIDTH'((int'(ptr_q) + 1 + int'(enc_idx)) % N_REQ);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (enc_found) begin
          state_d = BUSY;
          grant_d = N_REQ'(1) << win_idx;
          idx_d   = win_idx;
          ptr_d   = win_idx;
          valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (release_own) begin
          if (enc_found) begin
            grant_d = N_REQ'(1) << win_idx;
            idx_d   = win_idx;
            ptr_d   = win_idx;
          end else begin
            // grant_idx keeps the last owner while idle
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IDX_WIDTH'(N_REQ - 1);
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Bench for rr_packet_arbiter: directed spec scenarios plus randomized traffic against a packet-level model.
module tb_rr_packet_arbiter;
  localparam int N = 4;
`ifdef RR_PACKET_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] req, tail;
  logic         out_ready;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         grant_valid;
  logic         xfer;

  int n_tests = 0;
  int n_fail  = 0;

  rr_packet_arbiter #(.N_REQ(N), .IDX_WIDTH(2)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req         (req),
    .tail        (tail),
    .out_ready   (out_ready),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .xfer        (xfer)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the owner id (-1 when none), the rotation pointer and the last granted index.
  int m_owner = -1;
  int m_ptr   = N - 1;
  int m_last  = 0;

  function automatic int pick(input logic [N-1:0] r, input int p, input int excl);
    for (int k = 1; k <= N; k++) begin
      if (((p + k) % N) != excl && r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(negedge CLK) begin
    int  w;
    int  eg;
    bit  ex;
    bit  rel;
    if (RST) begin
      m_owner = -1;
      m_ptr   = N - 1;
      m_last  = 0;
      check("rst_grant", int'(grant), 0);
      check("rst_valid", int'(grant_valid), 0);
      check("rst_idx", int'(grant_idx), 0);
    end else begin
      eg = (m_owner >= 0) ? (1 << m_owner) : 0;
      ex = (m_owner >= 0) && req[m_owner] && out_ready;
      check("mdl_grant", int'(grant), eg);
      check("mdl_valid", int'(grant_valid), int'(m_owner >= 0));
      check("mdl_idx", int'(grant_idx), m_last);
      check("mdl_xfer", int'(xfer), int'(ex));
      if (m_owner < 0) begin
        w = pick(req, m_ptr, -1);
        if (w >= 0) begin
          m_owner = w; m_ptr = w; m_last = w;
        end
      end else begin
        rel = !req[m_owner] || (ex && (!LOCK || tail[m_owner]));
        if (rel) begin
          w = pick(req, m_ptr, m_owner);
          if (w >= 0) begin
            m_owner = w; m_ptr = w; m_last = w;
          end else begin
            m_owner = -1;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; req = '0; tail = '0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // rotation, no bubble
    req = 4'b1111; tail = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("rot_idx", int'(grant_idx), i % 4);
      check("rot_valid", int'(grant_valid), 1);
    end

    // async reset with owner 2 mid-packet
    req = 4'b0100; tail = 4'b0000;
    cyc();
    check("pre_rst_grant", int'(grant), 4'b0100);
    #2 RST = 1'b1;
    #1;
    check("async_rst_grant", int'(grant), 0);
    check("async_rst_valid", int'(grant_valid), 0);
    @(negedge CLK);
    cyc();
    RST = 1'b0; req = 4'b1111; tail = 4'b0000;
    cyc();
    check("post_rst_grant", int'(grant), 4'b0001);

    // 3-flit packet from requester 0, competing requester 1
    req = 4'b0011; tail = 4'b0000;
    cyc();
    check("lock_f1", int'(grant), LOCK ? 4'b0001 : 4'b0010);
    cyc();
    check("lock_f2", int'(grant), 4'b0001);
    tail = 4'b0001;
    cyc();
    check("lock_f3", int'(grant), 4'b0010);

    // backpressure with owner 2
    req = 4'b1111; tail = 4'b1111;
    cyc();
    check("bp_owner", int'(grant), 4'b0100);
    tail = 4'b0000; out_ready = 1'b0;
    #1 check("bp_xfer0", int'(xfer), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_hold", int'(grant), 4'b0100);
      check("bp_xfer", int'(xfer), 0);
    end
    out_ready = 1'b1;
    #1 check("bp_resume_xfer", int'(xfer), 1);
    cyc();
    check("bp_after", int'(grant), LOCK ? 4'b0100 : 4'b1000);

    // wrap to idle from owner 3
    if (LOCK) begin
      tail = 4'b0100;
      cyc();
      check("wrap_owner3", int'(grant), 4'b1000);
    end
    req = 4'b1000; tail = 4'b1000;
    cyc();
    check("idle_valid", int'(grant_valid), 0);
    check("idle_grant", int'(grant), 0);
    req = 4'b0000;
    cyc();
    check("idle_hold_idx", int'(grant_idx), 3);
    req = 4'b1000;
    cyc();
    check("regrant3", int'(grant), 4'b1000);

    // owner abort
    req = 4'b0010; tail = 4'b1000;
    cyc();
    check("abort_owner1", int'(grant), 4'b0010);
    req = 4'b0101; tail = 4'b0000;
    cyc();
    check("abort_grant", int'(grant), 4'b0100);
    check("abort_idx", int'(grant_idx), 2);

    // randomized traffic, model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (i == 1500) begin
        RST = 1'b1;
      end else begin
        RST = 1'b0;
      end
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      tail = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    cyc();
    RST = 1'b0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
